// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Wide enough for LAT-1 with LAT up to 15
  localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter2 : two-port round-robin selector on a last-served bit |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_CPU;
    if (req[PORT_CPU] && req[PORT_DMA]) begin
      grant = (last == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (req[PORT_DMA]) begin
      grant = PORT_DMA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : CPU/DMA arbiter for a single fixed-latency memory  |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = 1,
  parameter int AW  = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [31:0]   dma_rdata,

  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] c_LAT_M1 = CNT_W'(LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_port;
  logic               r_last;
  logic               r_we;
  logic [AW-1:0]      r_addr;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_cpu_rdata;
  logic [31:0]        r_dma_rdata;

  logic               w_grant;
  logic               w_valid;
  logic               w_sel;
  logic               w_in_acc;
  logic               w_first;
  logic               w_last_acc;

  rr_arbiter2 u_rr (
    .req   ({dma_req, cpu_req}),
    .last  (r_last),
    .grant (w_grant),
    .valid (w_valid)
  );

  assign w_sel      = ((r_state == IDLE) || (r_state == RESP)) && w_valid;
  assign w_in_acc   = (r_state == ACCESS);
  // The counter only counts down, so it equals LAT-1 only in the first ACCESS cycle
  assign w_first    = w_in_acc && (r_cnt == c_LAT_M1);
  assign w_last_acc = w_in_acc && (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RESP: w_state_nxt = w_valid ? ACCESS : IDLE;
      ACCESS:     if (r_cnt == '0) w_state_nxt = RESP;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port      <= PORT_CPU;
      r_last      <= PORT_DMA;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_sel) begin
        r_port <= w_grant;
        r_last <= w_grant;
        r_cnt  <= c_LAT_M1;
        if (w_grant == PORT_DMA) begin
          r_we    <= dma_we;
          r_addr  <= dma_addr;
          r_wdata <= dma_wdata;
        end else begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
      end else if (w_in_acc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_last_acc && !r_we) begin
        if (r_port == PORT_DMA) begin
          r_dma_rdata <= mem_rdata;
        end else begin
          r_cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    cpu_done  = 1'b0;
    dma_done  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_in_acc) begin
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      mem_read  = !r_we;
      mem_write = r_we && w_first;
      cpu_gnt   = w_first && (r_port == PORT_CPU);
      dma_gnt   = w_first && (r_port == PORT_DMA);
    end
    if (r_state == RESP) begin
      cpu_done = (r_port == PORT_CPU);
      dma_done = (r_port == PORT_DMA);
    end
    // Gated by reset so a request held during reset does not show as a stall
    cpu_stall = reset && !cpu_done && (cpu_req || (w_in_acc && (r_port == PORT_CPU)));
  end

  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : three arbiters (LAT=1,2,3) under directed and   |
// | random traffic.                     Revision : 1.0               |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req[3], cpu_we[3], dma_req[3], dma_we[3];
  logic [31:0] cpu_addr[3], cpu_wdata[3], dma_addr[3], dma_wdata[3], mem_rdata[3];
  logic        cpu_gnt[3], cpu_done[3], cpu_stall[3], dma_gnt[3], dma_done[3];
  logic        mem_read[3], mem_write[3];
  logic [31:0] cpu_rdata[3], dma_rdata[3], mem_addr[3], mem_wdata[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mem_arbiter #(.LAT(k + 1), .AW(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req[k]),
      .cpu_we    (cpu_we[k]),
      .cpu_addr  (cpu_addr[k]),
      .cpu_wdata (cpu_wdata[k]),
      .cpu_gnt   (cpu_gnt[k]),
      .cpu_done  (cpu_done[k]),
      .cpu_rdata (cpu_rdata[k]),
      .cpu_stall (cpu_stall[k]),
      .dma_req   (dma_req[k]),
      .dma_we    (dma_we[k]),
      .dma_addr  (dma_addr[k]),
      .dma_wdata (dma_wdata[k]),
      .dma_gnt   (dma_gnt[k]),
      .dma_done  (dma_done[k]),
      .dma_rdata (dma_rdata[k]),
      .mem_read  (mem_read[k]),
      .mem_write (mem_write[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata[k])
    );
  end

  typedef struct {
    logic        cpu_req;
    logic        dma_req;
    logic [31:0] rin;
    logic        cg, dg, cd, dd, rd;
    logic [31:0] addr;
    logic        stall;
    logic [31:0] crd, drd;
  } vec_t;

  task automatic chk(input string nm, input int k, input int cyc,
                     input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d actual=%h required=%h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl(input int k);
    return {cpu_gnt[k], dma_gnt[k], cpu_done[k], dma_done[k], cpu_stall[k],
            mem_read[k], mem_write[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dma_req[k] = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = '0;
      mem_rdata[k] = '0;
    end
  endtask

  // Leaves the caller at the start of cycle 0 with reset released and inputs idle
  task automatic do_reset();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 1'b1; dma_req[k] = 1'b1; cpu_addr[k] = 32'hFFFF_FFFF;
    end
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ctrl", k, 0, 96'({ctrl(k), dma_rdata[k]}), 96'd0);
      chk("reset_data", k, 0, {mem_addr[k], mem_wdata[k], cpu_rdata[k]}, 96'd0);
    end
    step();
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_table();
    vec_t tbl[6];
    tbl[0] = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,         32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h0,         32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h1234_5678, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h1234_5678, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h1234_5678, 32'hCAFE_F00D};
    tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h1234_5678, 32'hCAFE_F00D};
    do_reset();
    cpu_addr[0] = 32'h40;
    dma_addr[0] = 32'h80;
    for (int i = 0; i < 6; i++) begin
      cpu_req[0]   = tbl[i].cpu_req;
      dma_req[0]   = tbl[i].dma_req;
      mem_rdata[0] = tbl[i].rin;
      #2;
      chk("tbl_ctrl", 0, i,
          96'({cpu_gnt[0], dma_gnt[0], cpu_done[0], dma_done[0], mem_read[0], cpu_stall[0]}),
          96'({tbl[i].cg, tbl[i].dg, tbl[i].cd, tbl[i].dd, tbl[i].rd, tbl[i].stall}));
      chk("tbl_addr", 0, i, 96'(mem_addr[0]), 96'(tbl[i].addr));
      chk("tbl_rdata", 0, i, 96'({cpu_rdata[0], dma_rdata[0]}), 96'({tbl[i].crd, tbl[i].drd}));
      step();
    end
    // Both hold requests: CPU wins first (DMA served last), then strict alternation
    cpu_req[0] = 1'b1;
    dma_req[0] = 1'b1;
    for (int j = 0; j < 17; j++) begin
      logic [1:0] eg;
      eg = 2'b00;
      if (j % 2 == 1) eg = (((j - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
      #2;
      chk("alt_gnt", 0, j, 96'({cpu_gnt[0], dma_gnt[0]}), 96'(eg));
      step();
    end
  endtask

  task automatic test_write_lat3();
    logic [3:0]  ev;
    logic [63:0] eb;
    do_reset();
    cpu_req[2] = 1'b1; cpu_addr[2] = 32'h10; mem_rdata[2] = 32'h1111_2222;
    step();
    chk("w_cpu_gnt", 2, 1, 96'(cpu_gnt[2]), 96'd1);
    cpu_req[2] = 1'b0;
    step(); step(); step();
    chk("w_cpu_done", 2, 4, 96'({cpu_done[2], cpu_rdata[2]}), 96'({1'b1, 32'h1111_2222}));
    dma_req[2] = 1'b1; dma_we[2] = 1'b1; dma_addr[2] = 32'h100; dma_wdata[2] = 32'hDEAD_BEEF;
    mem_rdata[2] = 32'h5555_AAAA;
    for (int n = 1; n <= 5; n++) begin
      step();
      case (n)
        1:       ev = 4'b1100;
        4:       ev = 4'b0001;
        default: ev = 4'b0000;
      endcase
      eb = (n <= 3) ? {32'h100, 32'hDEAD_BEEF} : 64'd0;
      chk("w_ctrl", 2, n, 96'({dma_gnt[2], mem_write[2], mem_read[2], dma_done[2]}), 96'(ev));
      chk("w_bus", 2, n, 96'({mem_addr[2], mem_wdata[2]}), 96'(eb));
      if (n == 1) begin
        dma_req[2] = 1'b0; dma_addr[2] = 32'h999; dma_wdata[2] = 32'h0;
      end
    end
    chk("w_rdata_hold", 2, 6, 96'({cpu_rdata[2], dma_rdata[2]}), 96'({32'h1111_2222, 32'h0}));
  endtask

  task automatic test_reset_mid();
    do_reset();
    cpu_req[2] = 1'b1; cpu_addr[2] = 32'h40; mem_rdata[2] = 32'h7777_8888;
    step();
    chk("rm_gnt", 2, 1, 96'(cpu_gnt[2]), 96'd1);
    cpu_req[2] = 1'b0;
    step();
    chk("rm_acc2", 2, 2, 96'({mem_read[2], mem_addr[2]}), 96'({1'b1, 32'h40}));
    #1 reset = 1'b0;
    #1;
    chk("rm_zero_ctrl", 2, 2, 96'({ctrl(2), dma_rdata[2]}), 96'd0);
    chk("rm_zero_data", 2, 2, {mem_addr[2], mem_wdata[2], cpu_rdata[2]}, 96'd0);
    step();
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      chk("rm_quiet", 2, n, 96'({cpu_done[2], cpu_gnt[2], mem_read[2]}), 96'd0);
      step();
    end
    cpu_req[2] = 1'b1; cpu_addr[2] = 32'h44; mem_rdata[2] = 32'h0BAD_F00D;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 1) cpu_req[2] = 1'b0;
      chk("rm_redo_done", 2, n, 96'(cpu_done[2]), 96'(n == 4));
    end
    chk("rm_redo_rdata", 2, 4, 96'(cpu_rdata[2]), 96'(32'h0BAD_F00D));
  endtask

  task automatic test_addr_hold();
    do_reset();
    cpu_req[1] = 1'b1; cpu_addr[1] = 32'h40;
    step();
    chk("ah_c1", 1, 1, 96'({cpu_gnt[1], mem_read[1], mem_addr[1]}), 96'({1'b1, 1'b1, 32'h40}));
    step();
    cpu_req[1] = 1'b0; cpu_addr[1] = 32'h80;
    #1;
    chk("ah_c2", 1, 2, 96'({cpu_gnt[1], mem_read[1], mem_addr[1]}), 96'({1'b0, 1'b1, 32'h40}));
    step();
    chk("ah_c3", 1, 3, 96'({cpu_done[1], mem_addr[1]}), 96'({1'b1, 32'h0}));
  endtask

  // Transaction-level model: each access is a start cycle plus arithmetic on LAT
  task automatic test_random();
    bit          m_act[3], m_port[3], m_we[3], m_last[3], gs_cpu[3], gs_dma[3];
    int          m_start[3], m_resp[3];
    logic [31:0] m_addr[3], m_wd[3], m_rd[3][2];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 1'b0; m_last[k] = 1'b1; m_rd[k][0] = '0; m_rd[k][1] = '0;
      gs_cpu[k] = 1'b0; gs_dma[k] = 1'b0; m_start[k] = 0; m_resp[k] = 0;
      m_port[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        int lat;
        bit w;
        lat = k + 1;
        if (cyc > 0) begin
          if (m_act[k] && !m_we[k] && (cyc - 1 == m_start[k] + lat - 1))
            m_rd[k][m_port[k]] = mem_rdata[k];
          if ((!m_act[k] || (cyc - 1 >= m_resp[k])) && (cpu_req[k] || dma_req[k])) begin
            w = (cpu_req[k] && dma_req[k]) ? !m_last[k] : dma_req[k];
            m_act[k] = 1'b1; m_port[k] = w; m_last[k] = w;
            m_we[k]   = w ? dma_we[k] : cpu_we[k];
            m_addr[k] = w ? dma_addr[k] : cpu_addr[k];
            m_wd[k]   = w ? dma_wdata[k] : cpu_wdata[k];
            m_start[k] = cyc; m_resp[k] = cyc + lat;
          end
        end
        if (gs_cpu[k]) cpu_req[k] = 1'b0;
        if (!cpu_req[k]) begin
          cpu_we[k] = 1'($urandom_range(0, 1)); cpu_addr[k] = $urandom; cpu_wdata[k] = $urandom;
          if ($urandom_range(0, 9) < 4) cpu_req[k] = 1'b1;
        end
        if (gs_dma[k]) dma_req[k] = 1'b0;
        if (!dma_req[k]) begin
          dma_we[k] = 1'($urandom_range(0, 1)); dma_addr[k] = $urandom; dma_wdata[k] = $urandom;
          if ($urandom_range(0, 9) < 5) dma_req[k] = 1'b1;
        end
        mem_rdata[k] = $urandom;
      end
      #2;
      for (int k = 0; k < 3; k++) begin
        bit in_acc, first, ecd, edd, est;
        in_acc = m_act[k] && (cyc >= m_start[k]) && (cyc < m_start[k] + k + 1);
        first  = in_acc && (cyc == m_start[k]);
        ecd    = m_act[k] && (cyc == m_resp[k]) && !m_port[k];
        edd    = m_act[k] && (cyc == m_resp[k]) && m_port[k];
        est    = (cpu_req[k] || (in_acc && !m_port[k])) && !ecd;
        chk("rnd_ctrl", k, cyc, 96'(ctrl(k)),
            96'({first && !m_port[k], first && m_port[k], ecd, edd, est,
                 in_acc && !m_we[k], first && m_we[k]}));
        chk("rnd_bus", k, cyc, 96'({mem_addr[k], mem_wdata[k]}),
            in_acc ? 96'({m_addr[k], m_wd[k]}) : 96'd0);
        chk("rnd_rdata", k, cyc, 96'({cpu_rdata[k], dma_rdata[k]}),
            96'({m_rd[k][0], m_rd[k][1]}));
        gs_cpu[k] = first && !m_port[k];
        gs_dma[k] = first && m_port[k];
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_table();
    test_write_lat3();
    test_reset_mid();
    test_addr_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LAT, default 1, memory access latency in cycles (legal 1..15).
REQ-002 Parameter: AW, default 32, address width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port: cpu_req  input  1  CPU access request; held until cpu_gnt.
REQ-006 Port: cpu_we  input  1  CPU write (1) / read (0); held with cpu_req.
REQ-007 Port: cpu_addr  input  AW  CPU byte address.
REQ-008 Port: cpu_wdata  input  32  CPU write data.
REQ-009 Port: cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
REQ-010 Port: cpu_done  output  1  one-cycle pulse: CPU access complete; cpu_rdata valid for reads.
REQ-011 Port: cpu_rdata  output  32  CPU read data.
REQ-012 Port: cpu_stall  output  1  high while cpu_req pending or CPU access in flight, low in the cpu_done cycle.
REQ-013 Ports: dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata; same widths and meaning for the loader/DMA requester.
REQ-014 Port: mem_read  output  1  read strobe to the memory.
REQ-015 Port: mem_write  output  1  write strobe to the memory.
REQ-016 Port: mem_addr  output  AW  memory address.
REQ-017 Port: mem_wdata  output  32  memory write data.
REQ-018 Port: mem_rdata  input  32  memory read data, valid LAT cycles after mem_read first asserted.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP; one access in flight at a time.
REQ-020 IDLE or RESP with any req high SHALL select a winner, latch its we/addr/wdata and enter ACCESS next cycle; otherwise go to IDLE.
REQ-021 Arbitration SHALL be round-robin on a last-served flag; sole requester always wins; on a tie the port not last served wins.
REQ-022 The winner's gnt SHALL pulse high exactly in the first ACCESS cycle; the loser's gnt stays low and its request stays pending.
REQ-023 ACCESS SHALL last exactly LAT cycles, counted by a down-counter loaded with LAT-1.
REQ-024 mem_addr/mem_wdata SHALL come from the latched registers throughout ACCESS; zero outside ACCESS.
REQ-025 Read: mem_read high for all LAT ACCESS cycles; mem_rdata captured into the winner's rdata on the last ACCESS cycle.
REQ-026 Write: mem_write high only in the first ACCESS cycle; rdata unchanged.
REQ-027 RESP SHALL last one cycle with the winner's done high; request-to-done latency is LAT+1 cycles from the sampling edge.
REQ-028 Back-to-back: a request sampled in RESP SHALL enter ACCESS next cycle (throughput one access per LAT+1 cycles).
REQ-029 rdata outputs SHALL hold their last value until overwritten by a later read for the same port.
REQ-030 Changes on req/addr/we/wdata after gnt SHALL not affect the in-flight access.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, counter 0, last-served = DMA (so CPU wins the first tie).
REQ-032 During reset all gnt, done, stall, mem_read, mem_write SHALL be 0; mem_addr, mem_wdata, both rdata = 0.
REQ-033 Reset mid-ACCESS SHALL abandon the access with no done pulse; after release the first cycle is IDLE.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and port-index constants PORT_CPU=0, PORT_DMA=1.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant index and valid).

Verification
REQ-036 LAT=1, CPU read addr 0x40, mem_rdata=0x1234_5678 -> cpu_gnt at cycle 1, mem_read cycle 1, cpu_done + cpu_rdata=0x1234_5678 at cycle 2.
REQ-037 After reset, CPU and DMA request together at cycle 0 -> CPU granted cycle 1, DMA granted cycle 3, dma_done cycle 4.
REQ-038 Both requesting continuously for 8 accesses, LAT=1 -> grants alternate CPU,DMA,CPU,... one every 2 cycles.
REQ-039 LAT=3, DMA write addr 0x100 data 0xDEAD_BEEF -> mem_write exactly one cycle, ACCESS 3 cycles, dma_done 4 cycles after sampling, cpu_rdata unchanged.
REQ-040 Reset asserted in 2nd ACCESS cycle of LAT=3 read -> all outputs 0 immediately, no done pulse after release, next request served normally.
REQ-041 CPU changes cpu_addr to 0x80 in the cycle after cpu_gnt, LAT=2 -> mem_addr stays 0x40 for both ACCESS cycles.
